hs32_memarb: RTL and testbench
==============================

HS32_MEMARB -- requirements
Module: hs32_memarb

Interface
REQ-001 SHALL have parameter NCH, default 2: number of requesting channels, 1..8.
REQ-002 SHALL have parameter AW, default 32: address width.
REQ-003 SHALL have parameter DW, default 32: data width.
REQ-004 SHALL have parameter PRIO, default 0: arbitration mode, 0 = round-robin, 1 = fixed priority with lowest index winning.
REQ-005 SHALL have parameter TIMEOUT, default 0: bus timeout in cycles, 0 = disabled.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port ch_valid, input, NCH bits: per-channel request.
REQ-009 SHALL have port ch_rw, input, NCH bits: per-channel direction, 1 = write.
REQ-010 SHALL have port ch_addr, input, NCH*AW bits: channel i address occupies bits [i*AW +: AW].
REQ-011 SHALL have port ch_dtw, input, NCH*DW bits: channel i write data occupies bits [i*DW +: DW].
REQ-012 SHALL have port ch_dtr, output, DW bits: read data, shared by all channels.
REQ-013 SHALL have port ch_ready, output, NCH bits: one-cycle completion pulse per channel.
REQ-014 SHALL have port ch_err, output, 1 bit: timeout flag, qualified by ch_ready.
REQ-015 SHALL have port addr, output, AW bits: external bus address.
REQ-016 SHALL have port rw, output, 1 bit: external direction, 1 = write.
REQ-017 SHALL have port dout, output, DW bits: external write data.
REQ-018 SHALL have port wvalid, output, 1 bit: external transaction outstanding.
REQ-019 SHALL have port din, input, DW bits: external read data.
REQ-020 SHALL have port rvalid, input, 1 bit: external completion pulse; din valid on reads.

Function
REQ-021 SHALL implement FSM states IDLE, BUS and DONE; all outputs registered.
REQ-022 In IDLE with any ch_valid high, SHALL latch the winner index, addr, rw and dout, and enter BUS with wvalid=1 on the next cycle.
REQ-023 When PRIO=0, SHALL search channels starting at (last_grant+1) mod NCH and grant the first one with ch_valid high.
REQ-024 When PRIO=1, SHALL grant the lowest-index channel with ch_valid high.
REQ-025 In BUS, SHALL hold addr, rw, dout and wvalid=1 stable until rvalid is sampled high.
REQ-026 On rvalid in BUS, SHALL enter DONE with wvalid=0; on a read, SHALL load ch_dtr from din in the same edge.
REQ-027 In DONE, SHALL drive ch_ready[winner]=1 for exactly one cycle, update last_grant to the winner, then return to IDLE.
REQ-028 On a write, SHALL leave ch_dtr unchanged.
REQ-029 Minimum latency: request sampled at cycle 0 -> wvalid at cycle 1 -> ch_ready at cycle (rvalid cycle + 1); the next grant is sampled no earlier than the cycle after DONE.
REQ-030 SHALL ignore rvalid in IDLE and DONE.
REQ-031 When TIMEOUT>0, SHALL count cycles in BUS; after TIMEOUT cycles without rvalid, SHALL enter DONE with ch_err=1, wvalid=0 and ch_dtr unchanged.
REQ-032 If rvalid coincides with the timeout cycle, SHALL treat the transaction as a normal completion with ch_err=0.
REQ-033 SHALL drive ch_err=0 whenever ch_ready is all-zero.
REQ-034 If ch_valid drops after the grant, SHALL still complete the transaction and pulse ch_ready.
REQ-035 Requests that lose arbitration SHALL wait with no side effects; requesters SHALL hold ch_valid, ch_addr, ch_rw and ch_dtw stable until ch_ready.
REQ-036 When NCH=1, SHALL always grant channel 0, independent of PRIO.

Reset
REQ-037 reset low SHALL asynchronously force state=IDLE, wvalid=0, rw=0, addr=0, dout=0, ch_dtr=0, ch_ready=0, ch_err=0, timeout counter=0 and last_grant=NCH-1, so channel 0 wins first.
REQ-038 Reset asserted mid-transaction SHALL abandon the transaction, issue no ch_ready, and drop wvalid immediately.
REQ-039 After reset deasserts, SHALL resume arbitration at the first rising clk edge.

Verification
REQ-040 Bench SHALL cover: NCH=2, ch0 read addr 0x100, memory returns din=0xDEADBEEF with rvalid 2 cycles after wvalid -> ch_dtr=0xDEADBEEF, ch_ready=2'b01 for one cycle, ch_err=0.
REQ-041 Bench SHALL cover: PRIO=0, ch0 and ch1 request continuously -> grants alternate 0,1,0,1; PRIO=1 with the same stimulus -> channel 0 granted every time.
REQ-042 Bench SHALL cover: ch1 write addr 0x20, data 0x1234 -> addr=0x20, rw=1, dout=0x1234 held stable until rvalid; ch_dtr unchanged.
REQ-043 Bench SHALL cover: TIMEOUT=4, no rvalid -> ch_ready pulse with ch_err=1 four cycles after wvalid rises; and rvalid on exactly cycle 4 -> ch_err=0.
REQ-044 Bench SHALL cover: reset pulled low while wvalid=1 -> wvalid=0 with no clock edge and no ch_ready; after release, a pending ch0 request is granted first.
REQ-045 Bench SHALL cover: rvalid pulsed while IDLE -> no state change and no ch_ready.

Source files
------------

// File: rtl/hs32_memarb.sv
// hs32_memarb: arbitrates NCH request channels onto one external memory bus, with optional bus timeout
module hs32_memarb #(
    parameter int NCH     = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int PRIO    = 0,
    parameter int TIMEOUT = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NCH-1:0]    ch_valid,
    input  logic [NCH-1:0]    ch_rw,
    input  logic [NCH*AW-1:0] ch_addr,
    input  logic [NCH*DW-1:0] ch_dtw,
    output logic [DW-1:0]     ch_dtr,
    output logic [NCH-1:0]    ch_ready,
    output logic              ch_err,
    output logic [AW-1:0]     addr,
    output logic              rw,
    output logic [DW-1:0]     dout,
    output logic              wvalid,
    input  logic [DW-1:0]     din,
    input  logic              rvalid
);
    localparam int IW   = NCH > 1 ? $clog2(NCH) : 1;
    localparam int TW   = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    localparam int TLIM = TIMEOUT > 0 ? TIMEOUT - 1 : 0;
    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;
    state_t          state;
    logic [IW-1:0]   last_grant, winner, gnt, lo, hi;
    logic            hi_found, sel_rw, expired;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_dtw;
    logic [TW-1:0]   tcnt;
    assign expired = (TIMEOUT != 0) && (tcnt == TW'(TLIM));
    // lowest requester overall, and lowest requester above last_grant for the round-robin wrap
    always_comb begin
        lo = '0;
        hi = '0;
        hi_found = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (ch_valid[i]) begin
                lo = IW'(i);
                if (i > int'(last_grant)) begin
                    hi = IW'(i);
                    hi_found = 1'b1;
                end
            end
        end
        gnt = (PRIO == 0 && hi_found) ? hi : lo;
    end
    // route the granted channel's request fields
    always_comb begin
        sel_addr = '0;
        sel_dtw = '0;
        sel_rw = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (gnt == IW'(i)) begin
                sel_addr = ch_addr[i*AW +: AW];
                sel_dtw = ch_dtw[i*DW +: DW];
                sel_rw = ch_rw[i];
            end
        end
    end
    // IDLE -> BUS -> DONE transaction sequencer with registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            wvalid <= 1'b0;
            rw <= 1'b0;
            addr <= '0;
            dout <= '0;
            ch_dtr <= '0;
            ch_ready <= '0;
            ch_err <= 1'b0;
            tcnt <= '0;
            winner <= '0;
            last_grant <= IW'(NCH - 1);
        end else begin
            case (state)
                IDLE: if (|ch_valid) begin
                    winner <= gnt;
                    addr <= sel_addr;
                    rw <= sel_rw;
                    dout <= sel_dtw;
                    wvalid <= 1'b1;
                    tcnt <= '0;
                    state <= BUS;
                end
                BUS: if (rvalid || expired) begin
                    state <= DONE;
                    wvalid <= 1'b0;
                    ch_ready <= NCH'(1) << winner;
                    ch_err <= !rvalid;
                    if (rvalid && !rw) ch_dtr <= din;
                end else begin
                    tcnt <= tcnt + TW'(1);
                end
                DONE: begin
                    ch_ready <= '0;
                    ch_err <= 1'b0;
                    last_grant <= winner;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hs32_memarb.sv
// tb_hs32_memarb: vector table, directed corner cases and a randomized scoreboard run for hs32_memarb
module tb_hs32_memarb;
    localparam logic [31:0] K = 32'h1357_9BDF;
    typedef struct {
        int          ch;
        logic        rw;
        logic [31:0] addr, data, din;
        int          lat;
        logic [1:0]  exp_ready;
        logic        exp_err;
        logic [31:0] exp_dtr;
        int          exp_cyc;
    } vec_t;
    logic clk = 1'b0, reset = 1'b1;
    logic [1:0]  a_valid, a_rw, a_ready, b_valid, b_rw, b_ready;
    logic [63:0] a_addr, a_dtw, b_addr, b_dtw;
    logic [31:0] a_dtr, a_baddr, a_dout, a_din, b_dtr, b_baddr, b_dout, b_din;
    logic        a_err, a_brw, a_wvalid, a_rvalid, b_err, b_brw, b_wvalid, b_rvalid;
    int n_cmp = 0, n_bad = 0;
    int a_lat = 1, b_lat = 1, a_cnt = 0, b_cnt = 0;
    logic [31:0] a_rdat = '0;
    logic a_rand = 1'b0, force_rv = 1'b0;
    int n, na, nb, m_win, m_last, tx_cyc, m_done, in_tx;
    logic [31:0] m_dtr;
    logic exp_err, wv_prev;
    vec_t tv[7];
    always #5 clk = ~clk;
    hs32_memarb #(.NCH(2), .AW(32), .DW(32), .PRIO(0), .TIMEOUT(4)) u_a (
        .clk(clk), .reset(reset), .ch_valid(a_valid), .ch_rw(a_rw), .ch_addr(a_addr), .ch_dtw(a_dtw),
        .ch_dtr(a_dtr), .ch_ready(a_ready), .ch_err(a_err), .addr(a_baddr), .rw(a_brw), .dout(a_dout),
        .wvalid(a_wvalid), .din(a_din), .rvalid(a_rvalid));
    hs32_memarb #(.NCH(2), .AW(32), .DW(32), .PRIO(1), .TIMEOUT(0)) u_b (
        .clk(clk), .reset(reset), .ch_valid(b_valid), .ch_rw(b_rw), .ch_addr(b_addr), .ch_dtw(b_dtw),
        .ch_dtr(b_dtr), .ch_ready(b_ready), .ch_err(b_err), .addr(b_baddr), .rw(b_brw), .dout(b_dout),
        .wvalid(b_wvalid), .din(b_din), .rvalid(b_rvalid));
    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic wait_wv(output int c);
        c = 0;
        do begin tick(); c++; end while (!a_wvalid && c < 10);
    endtask
    task automatic wait_rdy(output int c);
        c = 0;
        while (a_ready == 2'b00 && c < 12) begin tick(); c++; end
    endtask
    // cyclic search for the first requester after the previous winner
    function automatic int pick(input logic [1:0] v, input int last);
        for (int k = 1; k <= 2; k++) if (v[(last + k) % 2]) return (last + k) % 2;
        return last;
    endfunction
    // single-channel transaction: request, hold bus stable, one-cycle completion pulse
    task automatic run_vec(input vec_t v, input string tag);
        int c;
        a_lat = v.lat;
        a_rdat = v.din;
        a_valid = '0;
        a_valid[v.ch] = 1'b1;
        a_rw[v.ch] = v.rw;
        a_addr[v.ch*32 +: 32] = v.addr;
        a_dtw[v.ch*32 +: 32] = v.data;
        wait_wv(c);
        chk({tag, "_req2wv"}, c, 1);
        c = 0;
        while (a_ready == 2'b00 && c < 12) begin
            chk({tag, "_hold"}, {a_wvalid, a_err, a_baddr, a_brw, a_dout}, {1'b1, 1'b0, v.addr, v.rw, v.data});
            tick();
            c++;
        end
        chk({tag, "_done"}, {a_ready, a_err, a_wvalid, a_dtr}, {v.exp_ready, v.exp_err, 1'b0, v.exp_dtr});
        chk({tag, "_cyc"}, c, v.exp_cyc);
        a_valid = '0;
        tick();
        chk({tag, "_pulse"}, {a_ready, a_err}, 3'b000);
        tick();
    endtask
    // memory responders: rvalid a programmable number of cycles into each bus phase (0 = never)
    initial begin
        a_rvalid = 1'b0;
        b_rvalid = 1'b0;
        a_din = '0;
        b_din = '0;
        forever begin
            @(negedge clk);
            a_cnt = a_wvalid ? a_cnt + 1 : 0;
            if (a_rand && a_wvalid && a_cnt == 1) a_lat = $urandom_range(1, 6);
            a_rvalid = force_rv || (a_wvalid && a_lat != 0 && a_cnt == a_lat);
            a_din = a_rvalid ? (a_rand ? ~a_baddr ^ K : a_rdat) : $urandom;
            b_cnt = b_wvalid ? b_cnt + 1 : 0;
            b_rvalid = b_wvalid && b_cnt == b_lat;
            b_din = $urandom;
        end
    end
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        tv[0] = '{0, 1'b0, 32'h100, 32'h0,    32'hDEADBEEF, 2, 2'b01, 1'b0, 32'hDEADBEEF, 2};
        tv[1] = '{1, 1'b1, 32'h20,  32'h1234, 32'hBAD0BAD0, 3, 2'b10, 1'b0, 32'hDEADBEEF, 3};
        tv[2] = '{0, 1'b0, 32'h44,  32'h0,    32'h55AA,     4, 2'b01, 1'b0, 32'h55AA,     4};
        tv[3] = '{1, 1'b0, 32'h48,  32'h0,    32'h7777,     0, 2'b10, 1'b1, 32'h55AA,     4};
        tv[4] = '{0, 1'b1, 32'h4C,  32'h9999, 32'h0,        5, 2'b01, 1'b1, 32'h55AA,     4};
        tv[5] = '{1, 1'b0, 32'h50,  32'h0,    32'hCAFEF00D, 1, 2'b10, 1'b0, 32'hCAFEF00D, 1};
        tv[6] = '{0, 1'b0, 32'h60,  32'h0,    32'h0BADF00D, 2, 2'b01, 1'b0, 32'h0BADF00D, 2};
        a_valid = '0; a_rw = '0; a_addr = '0; a_dtw = '0;
        b_valid = '0; b_rw = '0; b_addr = '0; b_dtw = '0;
        #1 reset = 1'b0;
        #1 chk("rst_state", {a_wvalid, a_brw, a_err, a_ready, a_baddr, a_dout, a_dtr, b_wvalid, b_ready}, '0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) run_vec(tv[i], $sformatf("v%0d", i));
        // both channels requesting continuously: round-robin alternates, fixed priority sticks to 0
        a_lat = 1;
        a_valid = 2'b11; a_rw = 2'b00; a_addr = {32'h204, 32'h200};
        b_valid = 2'b11; b_rw = 2'b00; b_addr = {32'h204, 32'h200};
        na = 0;
        nb = 0;
        for (int c = 0; c < 80 && (na < 4 || nb < 4); c++) begin
            tick();
            if (a_ready != 2'b00 && na < 4) begin
                chk($sformatf("rr%0d", na), a_ready, (na % 2) ? 2'b10 : 2'b01);
                na++;
            end
            if (b_ready != 2'b00 && nb < 4) begin
                chk($sformatf("fp%0d", nb), b_ready, 2'b01);
                nb++;
            end
        end
        chk("rr_count", na, 4);
        chk("fp_count", nb, 4);
        a_valid = '0;
        b_valid = '0;
        repeat (8) tick();
        // requester withdraws after the grant; the transaction still completes
        a_lat = 3;
        a_rdat = 32'hFEED0001;
        a_valid = 2'b10; a_rw = 2'b00; a_addr[63:32] = 32'h300;
        wait_wv(n);
        a_valid = '0;
        wait_rdy(n);
        chk("drop_done", {a_ready, a_err, a_dtr}, {2'b10, 1'b0, 32'hFEED0001});
        repeat (2) tick();
        // rvalid while idle has no effect
        force_rv = 1'b1;
        repeat (3) begin
            tick();
            chk("idle_rvalid", {a_ready, a_err, a_wvalid, a_dtr}, {2'b00, 1'b0, 1'b0, 32'hFEED0001});
        end
        force_rv = 1'b0;
        run_vec(tv[6], "post_idle");
        // reset mid-transaction: bus released immediately, channel 0 wins afterwards
        a_lat = 0;
        a_valid = 2'b11; a_rw = 2'b00; a_addr = {32'h704, 32'h700};
        wait_wv(n);
        chk("rst_pre_grant", {a_wvalid, a_baddr}, {1'b1, 32'h704});
        #2 reset = 1'b0;
        #1 chk("rst_async", {a_wvalid, a_ready, a_err, a_brw, a_baddr, a_dout, a_dtr, b_wvalid}, '0);
        repeat (2) begin
            tick();
            chk("rst_hold", {a_ready, a_wvalid}, 3'b000);
        end
        a_lat = 1;
        a_rdat = 32'h0000ABCD;
        reset = 1'b1;
        wait_wv(n);
        chk("rst_first_lat", n, 1);
        chk("rst_first_addr", a_baddr, 32'h700);
        wait_rdy(n);
        chk("rst_first_done", {a_ready, a_err, a_dtr}, {2'b01, 1'b0, 32'h0000ABCD});
        a_valid = '0;
        repeat (2) tick();
        // randomized traffic against a transaction-level scoreboard
        a_rand = 1'b1;
        m_last = 0;
        m_dtr = 32'h0000ABCD;
        m_win = 0;
        in_tx = 0;
        m_done = 0;
        wv_prev = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            tick();
            if (a_wvalid && !wv_prev) begin
                m_win = pick(a_valid, m_last);
                in_tx = 1;
                tx_cyc = 0;
            end
            if (a_wvalid) begin
                tx_cyc++;
                chk("rnd_bus", {a_baddr, a_brw, a_dout}, {a_addr[m_win*32 +: 32], a_rw[m_win], a_dtw[m_win*32 +: 32]});
            end
            if (a_ready != 2'b00) begin
                exp_err = a_lat > 4;
                if (!exp_err && !a_rw[m_win]) m_dtr = ~a_addr[m_win*32 +: 32] ^ K;
                chk("rnd_done", {a_ready, a_err, a_wvalid, a_dtr}, {(in_tx != 0) ? 2'(1 << m_win) : 2'b00, exp_err, 1'b0, m_dtr});
                chk("rnd_lat", tx_cyc, exp_err ? 4 : a_lat);
                m_last = m_win;
                in_tx = 0;
                a_valid[m_win] = 1'b0;
                m_done++;
            end else begin
                chk("rnd_err_idle", a_err, 1'b0);
            end
            wv_prev = a_wvalid;
            for (int k = 0; k < 2; k++) begin
                if (!a_valid[k] && $urandom_range(0, 2) == 0) begin
                    a_valid[k] = 1'b1;
                    a_rw[k] = 1'($urandom_range(0, 1));
                    a_addr[k*32 +: 32] = $urandom;
                    a_dtw[k*32 +: 32] = $urandom;
                end
            end
        end
        chk("rnd_progress", m_done > 100, 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
